// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath sizing and the hardwired-zero register index.
package cpu_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned REG_ZERO  = 0;

  // True when addr names a real (writable, trackable) register.
  function automatic logic is_live_reg(input logic [31:0] addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One register-file read lane: storage mux, W1-over-W0 bypass priority, busy masking.
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(DEPTH)
)(
  input  logic [AW-1:0]                rd_addr_i,
  input  logic [DEPTH-1:0][XLEN-1:0]   regs_i,
  input  logic [DEPTH-1:0]             busy_i,
  input  logic                         we0_i,
  input  logic [AW-1:0]                waddr0_i,
  input  logic [XLEN-1:0]              wdata0_i,
  input  logic                         we1_i,
  input  logic [AW-1:0]                waddr1_i,
  input  logic [XLEN-1:0]              wdata1_i,
  output logic [XLEN-1:0]              rd_data_o,
  output logic                         rd_busy_o
);

  localparam logic BYP_EN = (BYPASS != 0);

  logic rd_live;
  logic hit0;
  logic hit1;

  assign rd_live = is_live_reg(32'(rd_addr_i));

  // A hit implies a live address, so address 0 can never be served from the bypass.
  assign hit1 = BYP_EN && rd_live && we1_i && (waddr1_i == rd_addr_i);
  assign hit0 = BYP_EN && rd_live && we0_i && (waddr0_i == rd_addr_i);

  always_comb begin
    rd_data_o = '0;
    if (!rd_live) begin
      rd_data_o = '0;
    end else if (hit1) begin
      rd_data_o = wdata1_i;
    end else if (hit0) begin
      rd_data_o = wdata0_i;
    end else begin
      rd_data_o = regs_i[rd_addr_i];
    end
  end

  // Bypassed data is the producer's result, so the operand is no longer pending.
  assign rd_busy_o = busy_i[rd_addr_i] && !(hit0 || hit1);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with two write ports, optional write-to-read bypass and busy scoreboard.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NRD*AW-1:0]     rd_addr_i,
  output logic [NRD*XLEN-1:0]   rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic                  we0_i,
  input  logic [AW-1:0]         waddr0_i,
  input  logic [XLEN-1:0]       wdata0_i,
  input  logic                  we1_i,
  input  logic [AW-1:0]         waddr1_i,
  input  logic [XLEN-1:0]       wdata1_i,
  input  logic                  alloc_en_i,
  input  logic [AW-1:0]         alloc_addr_i,
  output logic [DEPTH-1:0]      busy_vec_o
);

  // No handshake: writes and allocs are accepted on every clock edge unconditionally.

  logic [DEPTH-1:0][XLEN-1:0] regs;
  logic [DEPTH-1:0]           busy;

  logic wr0_ok;
  logic wr1_ok;
  logic alloc_ok;

  assign wr0_ok   = we0_i && is_live_reg(32'(waddr0_i));
  assign wr1_ok   = we1_i && is_live_reg(32'(waddr1_i));
  assign alloc_ok = alloc_en_i && is_live_reg(32'(alloc_addr_i));

  // W1 is assigned after W0, so on an address collision the long-latency result is kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs <= '0;
    end else begin
      if (wr0_ok) begin
        regs[waddr0_i] <= wdata0_i;
      end
      if (wr1_ok) begin
        regs[waddr1_i] <= wdata1_i;
      end
    end
  end

  // Alloc is assigned last so a newly issued producer outranks a retiring one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy <= '0;
    end else begin
      if (wr0_ok) begin
        busy[waddr0_i] <= 1'b0;
      end
      if (wr1_ok) begin
        busy[waddr1_i] <= 1'b0;
      end
      if (alloc_ok) begin
        busy[alloc_addr_i] <= 1'b1;
      end
    end
  end

  assign busy_vec_o = busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rd_port #(
      .XLEN   (XLEN),
      .DEPTH  (DEPTH),
      .BYPASS (BYPASS),
      .AW     (AW)
    ) u_rd_port (
      .rd_addr_i (rd_addr_i[k*AW +: AW]),
      .regs_i    (regs),
      .busy_i    (busy),
      .we0_i     (we0_i),
      .waddr0_i  (waddr0_i),
      .wdata0_i  (wdata0_i),
      .we1_i     (we1_i),
      .waddr1_i  (waddr1_i),
      .wdata1_i  (wdata1_i),
      .rd_data_o (rd_data_o[k*XLEN +: XLEN]),
      .rd_busy_o (rd_busy_o[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic                we0, we1, alloc_en;
  logic [AW-1:0]       waddr0, waddr1, alloc_addr;
  logic [XLEN-1:0]     wdata0, wdata1;
  logic [DEPTH-1:0]    busy_vec, busy_vec_nb;

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(1)) dut (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .busy_vec_o(busy_vec)
  );

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
    .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .busy_vec_o(busy_vec_nb)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [XLEN-1:0] ref_regs [DEPTH];
  bit              ref_busy [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit served_by_bypass(input logic [AW-1:0] a, input bit byp);
    if (!byp || a == 0) return 1'b0;
    return (we1 && waddr1 == a) || (we0 && waddr0 == a);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && we1 && waddr1 == a) return wdata1;
    if (byp && we0 && waddr0 == a) return wdata0;
    return ref_regs[a];
  endfunction

  function automatic logic [DEPTH-1:0] exp_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = ref_busy[i];
    return v;
  endfunction

  task automatic update_model();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ref_regs[i] = '0;
        ref_busy[i] = 1'b0;
      end
    end else begin
      if (we0 && waddr0 != 0) begin ref_regs[waddr0] = wdata0; ref_busy[waddr0] = 1'b0; end
      if (we1 && waddr1 != 0) begin ref_regs[waddr1] = wdata1; ref_busy[waddr1] = 1'b0; end
      if (alloc_en && alloc_addr != 0) ref_busy[alloc_addr] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic [AW-1:0] a;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      check($sformatf("rd_data%0d_byp a=%0d", k, a), 64'(rd_data[k*XLEN +: XLEN]), 64'(exp_data(a, 1'b1)));
      check($sformatf("rd_data%0d_nobyp a=%0d", k, a), 64'(rd_data_nb[k*XLEN +: XLEN]), 64'(exp_data(a, 1'b0)));
      check($sformatf("rd_busy%0d_byp a=%0d", k, a), 64'(rd_busy[k]),
            64'(ref_busy[a] && !served_by_bypass(a, 1'b1)));
      check($sformatf("rd_busy%0d_nobyp a=%0d", k, a), 64'(rd_busy_nb[k]), 64'(ref_busy[a]));
    end
    check("busy_vec_byp", 64'(busy_vec), 64'(exp_vec()));
    check("busy_vec_nobyp", 64'(busy_vec_nb), 64'(exp_vec()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0;
    waddr0 = '0; waddr1 = '0; alloc_addr = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic settle();
    #2;
    check_outputs();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    logic [AW-1:0] a0, a1;
    idle();
    rst        = ($urandom_range(0, 39) == 0);
    we0        = $urandom_range(0, 1);
    we1        = $urandom_range(0, 2) == 0;
    alloc_en   = $urandom_range(0, 2) != 0;
    waddr0     = AW'($urandom_range(0, 7));
    waddr1     = AW'($urandom_range(0, 7));
    alloc_addr = AW'($urandom_range(0, 7));
    wdata0     = $urandom;
    wdata1     = $urandom;
    // Bias reads toward the write addresses so bypass paths are exercised often.
    case ($urandom_range(0, 3))
      0:       a0 = waddr0;
      1:       a0 = waddr1;
      default: a0 = AW'($urandom_range(0, DEPTH - 1));
    endcase
    a1 = ($urandom_range(0, 1) == 1) ? waddr1 : AW'($urandom_range(0, 7));
    set_rd(a0, a1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    set_rd('0, '0);
    rst = 1'b1;
    @(negedge clk);
    clock_edge();

    // Reset state: every address on both ports reads zero, nothing busy.
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), AW'(DEPTH - 1 - a));
      settle();
      clock_edge();
    end
    check("reset_busy_vec", 64'(busy_vec), 64'h0);

    // Same-cycle bypass vs. next-cycle visibility.
    idle(); we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; set_rd(5'd5, 5'd0);
    settle();
    check("t2_bypass_same", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("t2_nobypass_same", 64'(rd_data_nb[31:0]), 64'h0);
    clock_edge();
    idle(); set_rd(5'd5, 5'd5);
    settle();
    check("t2_nobypass_next", 64'(rd_data_nb[31:0]), 64'hDEADBEEF);
    clock_edge();

    // Write collision: W1 wins.
    idle(); we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222; set_rd(5'd7, 5'd7);
    settle();
    check("t3_bypass_same", 64'(rd_data[31:0]), 64'h22222222);
    clock_edge();
    idle(); set_rd(5'd7, 5'd7);
    settle();
    check("t3_stored_next", 64'(rd_data_nb[63:32]), 64'h22222222);
    clock_edge();

    // Zero register ignores writes and allocs.
    idle(); we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF; alloc_en = 1'b1; alloc_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    settle();
    check("t4_x0_same", 64'(rd_data[31:0]), 64'h0);
    clock_edge();
    idle();
    settle();
    check("t4_x0_next", 64'(rd_data_nb[31:0]), 64'h0);
    check("t4_busy0", 64'(busy_vec[0]), 64'h0);
    clock_edge();

    // Scoreboard: alloc, alloc+write race, then clearing write.
    idle(); alloc_en = 1'b1; alloc_addr = 5'd9; set_rd(5'd9, 5'd0);
    settle();
    clock_edge();
    idle(); set_rd(5'd9, 5'd9);
    settle();
    check("t5_busy9_set", 64'(busy_vec[9]), 64'h1);
    check("t5_rd_busy_set", 64'(rd_busy[0]), 64'h1);
    clock_edge();
    idle(); alloc_en = 1'b1; alloc_addr = 5'd9; we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h0BADF00D;
    settle();
    clock_edge();
    idle(); set_rd(5'd9, 5'd0);
    settle();
    check("t5_busy9_realloc", 64'(busy_vec[9]), 64'h1);
    clock_edge();
    idle(); we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hCAFEF00D; set_rd(5'd9, 5'd0);
    settle();
    check("t5_rd_busy_bypassed", 64'(rd_busy[0]), 64'h0);
    check("t5_rd_busy_nobyp", 64'(rd_busy_nb[0]), 64'h1);
    clock_edge();
    idle(); set_rd(5'd9, 5'd9);
    settle();
    check("t5_busy9_cleared", 64'(busy_vec[9]), 64'h0);
    check("t5_data9", 64'(rd_data[31:0]), 64'hCAFEF00D);
    clock_edge();

    // Reset mid-operation discards the pending write and alloc.
    idle(); we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h12345678; alloc_en = 1'b1; alloc_addr = 5'd4;
    settle();
    clock_edge();
    idle(); rst = 1'b1; we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
    alloc_en = 1'b1; alloc_addr = 5'd3; set_rd(5'd3, 5'd4);
    settle();
    clock_edge();
    idle(); set_rd(5'd3, 5'd4);
    settle();
    check("t6_x3_after_rst", 64'(rd_data[31:0]), 64'h0);
    check("t6_busy3_after_rst", 64'(busy_vec[3]), 64'h0);
    check("t6_busy_vec_after_rst", 64'(busy_vec), 64'h0);
    clock_edge();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      rand_inputs();
      settle();
      clock_edge();
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file: NRD read ports, two write ports, optional same-cycle write-to-read bypass, and a per-register busy scoreboard.
- Sits in the ID stage of the CPU pipeline.
- W0 is fed by the ALU/MEM writeback path and W1 by the long-latency unit writeback.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width in bits
- DEPTH, 32, number of architectural registers; must be a power of 2 and at least 2
- NRD, 2, number of read ports
- BYPASS, 1, 1 = a read returns same-cycle write data on an address match; 0 = a read returns stored contents only
- AW (localparam), $clog2(DEPTH), register address width

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  synchronous, active-high reset
- rd_addr_i  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd_data_o  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]; combinational
- rd_busy_o  out  NRD  per-read-port busy flag; combinational
- we0_i  in  1  write enable, port 0
- waddr0_i  in  AW  write address, port 0
- wdata0_i  in  XLEN  write data, port 0
- we1_i  in  1  write enable, port 1
- waddr1_i  in  AW  write address, port 1
- wdata1_i  in  XLEN  write data, port 1
- alloc_en_i  in  1  marks a register busy (producer issued)
- alloc_addr_i  in  AW  register to mark busy
- busy_vec_o  out  DEPTH  registered scoreboard vector; bit 0 is always 0

Behaviour:
- Reset:
  - rst_i high at a clock edge clears every register to 0 and every busy bit to 0.
  - Reset takes priority over writes and alloc in the same cycle.
  - After that edge, rd_data_o = 0, rd_busy_o = 0 and busy_vec_o = 0.
  - Reset asserted mid-operation discards any pending write or alloc.
- Write:
  - At the clock edge, if weN_i = 1 and waddrN_i != 0, register[waddrN_i] <= wdataN_i.
  - Both ports writing the same non-zero address in the same cycle: W1 data is stored and W0 is dropped.
  - Different addresses: both writes are stored.
- Address 0:
  - Reads always return 0.
  - Writes to address 0 are ignored.
  - An alloc to address 0 is ignored, so busy[0] stays 0.
- Read path (zero latency):
  - When BYPASS = 1 and rd_addr == waddr1_i with we1_i and a non-zero address: returns wdata1_i.
  - Otherwise, when BYPASS = 1 and it matches the enabled, non-zero W0 address: returns wdata0_i.
  - Otherwise: returns register[rd_addr].
  - When BYPASS = 0: always returns register[rd_addr]; new data becomes visible the cycle after the write.
- Scoreboard:
  - Set: an alloc at the edge sets busy[alloc_addr_i].
  - Clear: an enabled, non-zero write on either port clears busy[waddr].
  - Alloc and write to the same address in the same cycle: busy ends at 1 (the new producer wins).
  - rd_busy_o[k] = busy[rd_addr_k] AND NOT bypass_hit_k; it is 0 whenever port k is served from the bypass.
  - With BYPASS = 0, rd_busy_o[k] = busy[rd_addr_k].
- No handshake back-pressure: the block always accepts writes and allocs.

Decomposition:
- Shared package (cpu_pkg) holds:
  - default XLEN and DEPTH constants
  - the REG_ZERO constant (0)
- One natural sub-module, regfile_rd_port:
  - a single read lane containing the mux, the bypass priority and the busy masking
  - instantiated NRD times in a generate loop
- Storage and the scoreboard stay in the top module.

Test Plan:
1. Reset then read: hold rst_i one cycle, read all 32 addresses on both ports -> every rd_data_o = 0, busy_vec_o = 0.
2. Write then bypass: we0 to x5 with 0xDEADBEEF, rd_addr0 = 5 in the same cycle -> rd_data_o port 0 = 0xDEADBEEF (BYPASS = 1); it reads 0 that cycle and 0xDEADBEEF the next cycle (BYPASS = 0).
3. Write collision: we0 to x7 with 0x11111111 and we1 to x7 with 0x22222222 in the same cycle -> the next-cycle read of x7 = 0x22222222; the same-cycle bypass read = 0x22222222.
4. Zero register: we1 to x0 with 0xFFFFFFFF plus alloc of x0 -> read x0 = 0, busy_vec_o[0] = 0.
5. Scoreboard sequence:
   - alloc x9 -> busy_vec_o[9] = 1 next cycle and rd_busy_o = 1 on a read of x9.
   - Alloc and we0 to x9 in the same cycle -> busy stays 1.
   - we1 to x9 alone -> the same-cycle rd_busy_o = 0 and busy_vec_o[9] = 0 the next cycle.
6. Reset mid-operation: we0 to x3 with 0xA5A5A5A5 and alloc x3 while rst_i = 1 -> next cycle: read x3 = 0, busy_vec_o[3] = 0.
